// File: rtl/mem_access_if.sv
// Request/acknowledge data bus between the MEM stage and the memory system.
// The master registers the request side; the slave answers with a one-cycle ack.
interface mem_bus_if;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MIPS MEM stage: one outstanding bus transaction per instruction, load
// alignment/extension, store strobes, address-error flags and stall request.
//
// state | meaning
// IDLE  | no transaction; a live op launches the bus request at the next edge
// WAIT  | request outstanding, bus outputs held until bus_ack
// DONE  | load word captured; held here while the MEM stage is stalled
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        i_valid,
  input  logic [3:0]  i_mem_op,
  input  logic [31:0] i_d1,
  input  logic [31:0] i_d2,
  input  logic [4:0]  i_rn,
  input  logic        i_write_regfile,
  input  logic        i_mem_to_regfile,
  input  logic        i_mtc0_we,
  output logic [31:0] o_d1,
  output logic [31:0] o_d2,
  output logic [4:0]  o_rn,
  output logic        o_write_regfile,
  output logic        o_mem_to_regfile,
  output logic        o_mtc0_we,
  output logic        o_stallreq,
  output logic        o_adel,
  output logic        o_ades,
  output logic [31:0] o_badvaddr,
  mem_bus_if.master   bus
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        req_q, req_nxt;
  logic        wr_q, wr_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [3:0]  wstrb_q, wstrb_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [31:0] load_q, load_nxt;

  logic        is_load, is_store, misaligned, live;
  logic [1:0]  a;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic unused_stall;
  assign unused_stall = &{1'b0, stall[5], stall[3:0]};

  assign a = i_d1[1:0];

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    st_strb    = 4'b0000;
    st_data    = 32'h0;
    case (i_mem_op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load    = 1'b1;
        misaligned = a[0];
      end
      OP_LW: begin
        is_load    = 1'b1;
        misaligned = |a;
      end
      OP_SB: begin
        is_store = 1'b1;
        st_strb  = 4'b0001 << a;
        st_data  = {4{i_d2[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = a[0];
        st_strb    = a[1] ? 4'b1100 : 4'b0011;
        st_data    = {2{i_d2[15:0]}};
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = |a;
        st_strb    = 4'b1111;
        st_data    = i_d2;
      end
      default: ;
    endcase
  end

  assign o_adel = i_valid & is_load & misaligned;
  assign o_ades = i_valid & is_store & misaligned;
  assign live   = i_valid & (is_load | is_store) & ~misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      load_q  <= 32'h0;
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      wr_q    <= wr_nxt;
      addr_q  <= addr_nxt;
      wstrb_q <= wstrb_nxt;
      wdata_q <= wdata_nxt;
      load_q  <= load_nxt;
    end
  end

  // WAIT does not look at live: a transaction on the bus always completes.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    wr_nxt    = wr_q;
    addr_nxt  = addr_q;
    wstrb_nxt = wstrb_q;
    wdata_nxt = wdata_q;
    load_nxt  = load_q;
    case (state)
      S_IDLE: begin
        if (live) begin
          req_nxt   = 1'b1;
          wr_nxt    = is_store;
          addr_nxt  = {i_d1[31:2], 2'b00};
          wstrb_nxt = st_strb;
          wdata_nxt = st_data;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.bus_ack) begin
          req_nxt   = 1'b0;
          load_nxt  = bus.bus_rdata;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall[4]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

  always_comb begin
    ld_byte = load_q[7:0];
    case (a)
      2'd1:    ld_byte = load_q[15:8];
      2'd2:    ld_byte = load_q[23:16];
      2'd3:    ld_byte = load_q[31:24];
      default: ld_byte = load_q[7:0];
    endcase
    ld_half = a[1] ? load_q[31:16] : load_q[15:0];
    case (i_mem_op)
      OP_LB:   o_d2 = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  o_d2 = {24'h0, ld_byte};
      OP_LH:   o_d2 = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  o_d2 = {16'h0, ld_half};
      OP_LW:   o_d2 = load_q;
      default: o_d2 = i_d2;
    endcase
  end

  assign o_stallreq       = live & (state != S_DONE) & ~reset;
  assign o_d1             = i_d1;
  assign o_badvaddr       = i_d1;
  assign o_rn             = i_rn;
  assign o_mem_to_regfile = i_mem_to_regfile;
  assign o_mtc0_we        = i_mtc0_we;
  assign o_write_regfile  = i_write_regfile & i_valid & ~(o_adel | o_ades);

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized loads and
// stores against an arithmetic reference model of alignment, strobes and extension.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  stall = '0;
  logic        i_valid = 1'b0;
  logic [3:0]  i_mem_op = '0;
  logic [31:0] i_d1 = '0, i_d2 = '0;
  logic [4:0]  i_rn = '0;
  logic        i_write_regfile = 1'b0, i_mem_to_regfile = 1'b0, i_mtc0_we = 1'b0;
  logic [31:0] o_d1, o_d2, o_badvaddr;
  logic [4:0]  o_rn;
  logic        o_write_regfile, o_mem_to_regfile, o_mtc0_we;
  logic        o_stallreq, o_adel, o_ades;

  int vectors = 0;
  int errors  = 0;

  mem_bus_if bus ();

  mem_access dut (
    .clk(clk), .reset(reset), .stall(stall), .i_valid(i_valid), .i_mem_op(i_mem_op),
    .i_d1(i_d1), .i_d2(i_d2), .i_rn(i_rn), .i_write_regfile(i_write_regfile),
    .i_mem_to_regfile(i_mem_to_regfile), .i_mtc0_we(i_mtc0_we),
    .o_d1(o_d1), .o_d2(o_d2), .o_rn(o_rn), .o_write_regfile(o_write_regfile),
    .o_mem_to_regfile(o_mem_to_regfile), .o_mtc0_we(o_mtc0_we),
    .o_stallreq(o_stallreq), .o_adel(o_adel), .o_ades(o_ades),
    .o_badvaddr(o_badvaddr), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit ref_aligned(input int op, input logic [31:0] addr);
    if (op == 3 || op == 4 || op == 7) return (addr % 2) == 0;
    if (op == 5 || op == 8) return (addr % 4) == 0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr, input logic [31:0] w);
    longint b, h, a;
    a = longint'(addr % 4);
    b = longint'((w >> (8 * a)) % 256);
    h = longint'((w >> (16 * (a / 2))) % 65536);
    case (op)
      1: return (b >= 128) ? 32'(b - 256) : 32'(b);
      2: return 32'(b);
      3: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      4: return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input int op, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    case (op)
      6: return 4'(1 << a);
      7: return (a >= 2) ? 4'd12 : 4'd3;
      8: return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] d);
    case (op)
      6: return (d % 256) * 32'h01010101;
      7: return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // Presents one aligned memory op, acks in cycle k, holds stall[4] for `hold`
  // cycles in DONE, and checks every cycle. Returns at posedge+1 after the op.
  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] d2,
                        input logic [31:0] rdata, input int k, input int hold);
    logic [31:0] exp_addr;
    exp_addr = addr - (addr % 4);
    i_valid = 1'b1; i_mem_op = 4'(op); i_d1 = addr; i_d2 = d2;
    i_write_regfile = 1'b1; i_rn = 5'($urandom_range(0, 31));
    for (int c = 0; c <= k + 1 + hold; c++) begin
      bus.bus_ack   = (c == k);
      bus.bus_rdata = (c == k) ? rdata : 32'($urandom);
      stall[4]      = (c >= k + 1) && (c < k + 1 + hold);
      @(negedge clk);
      vectors++;
      if (o_stallreq !== (c <= k)) begin
        errors++; $display("FAIL stallreq op=%0d cyc=%0d got %b want %b", op, c, o_stallreq, (c <= k));
      end
      vectors++;
      if (bus.bus_req !== (c >= 1 && c <= k)) begin
        errors++; $display("FAIL bus_req op=%0d cyc=%0d got %b want %b", op, c, bus.bus_req, (c >= 1 && c <= k));
      end
      if (c >= 1 && c <= k) begin
        vectors++;
        if (bus.bus_addr !== exp_addr || bus.bus_wr !== (op >= 6)) begin
          errors++; $display("FAIL bus_addr_wr op=%0d cyc=%0d got %h/%b want %h/%b", op, c, bus.bus_addr, bus.bus_wr, exp_addr, (op >= 6));
        end
        if (op >= 6) begin
          vectors++;
          if (bus.bus_wstrb !== ref_strb(op, addr) || bus.bus_wdata !== ref_wdata(op, d2)) begin
            errors++; $display("FAIL store_lanes op=%0d addr=%h got %b/%h want %b/%h", op, addr, bus.bus_wstrb, bus.bus_wdata, ref_strb(op, addr), ref_wdata(op, d2));
          end
        end
      end
      if (c >= k + 1) begin
        vectors++;
        if (o_d2 !== ((op <= 5) ? ref_load(op, addr, rdata) : d2) || o_write_regfile !== 1'b1) begin
          errors++; $display("FAIL result op=%0d addr=%h cyc=%0d got %h/%b want %h/1", op, addr, c, o_d2, o_write_regfile, (op <= 5) ? ref_load(op, addr, rdata) : d2);
        end
      end
      @(posedge clk); #1;
    end
    bus.bus_ack = 1'b0; stall[4] = 1'b0; i_valid = 1'b0; i_mem_op = 4'd0;
  endtask

  task automatic run_misaligned(input int op, input logic [31:0] addr);
    i_valid = 1'b1; i_mem_op = 4'(op); i_d1 = addr; i_d2 = 32'($urandom); i_write_regfile = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({o_adel, o_ades} !== {(op <= 5), (op >= 6)} || o_write_regfile !== 1'b0 || o_badvaddr !== addr) begin
        errors++; $display("FAIL addr_error op=%0d addr=%h got adel=%b ades=%b wr=%b bad=%h", op, addr, o_adel, o_ades, o_write_regfile, o_badvaddr);
      end
      vectors++;
      if (o_stallreq !== 1'b0 || bus.bus_req !== 1'b0) begin
        errors++; $display("FAIL misaligned_no_bus op=%0d got stallreq=%b req=%b want 0/0", op, o_stallreq, bus.bus_req);
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_mem_op = 4'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_valid = 1'b1; i_mem_op = 4'd5; i_d1 = 32'h100; i_write_regfile = 1'b1;
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.bus_req, bus.bus_wr, bus.bus_addr, bus.bus_wstrb, bus.bus_wdata} !== 70'h0) begin
      errors++; $display("FAIL reset_bus got req=%b wr=%b addr=%h strb=%b wdata=%h want zeros", bus.bus_req, bus.bus_wr, bus.bus_addr, bus.bus_wstrb, bus.bus_wdata);
    end
    vectors++;
    if (o_stallreq !== 1'b0 || o_d2 !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got stallreq=%b d2=%h want 0/00000000", o_stallreq, o_d2);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(5, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
    run_op(1, 32'h103, 32'h0, 32'h80FFFFFF, 1, 0);
    run_op(2, 32'h103, 32'h0, 32'h80FFFFFF, 2, 0);
    run_op(3, 32'h102, 32'h0, 32'h80011234, 1, 0);
    run_op(7, 32'h202, 32'h1234ABCD, 32'h0, 2, 0);
    run_op(6, 32'h201, 32'h000000A5, 32'h0, 1, 0);
  endtask

  task automatic test_misaligned();
    run_misaligned(5, 32'h102);
    run_misaligned(8, 32'h101);
    run_misaligned(4, 32'h105);
  endtask

  // Non-memory op passes through; a stray ack while IDLE must change nothing.
  task automatic test_passthrough(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      i_valid = 1'b1; i_mem_op = 4'(c % 2 == 0 ? 0 : 12); i_d1 = 32'($urandom); i_d2 = 32'($urandom);
      i_rn = 5'($urandom_range(0, 31)); i_write_regfile = 1'b1; i_mtc0_we = c[0]; i_mem_to_regfile = c[1];
      bus.bus_ack = (c == 1); bus.bus_rdata = 32'($urandom);
      @(negedge clk);
      vectors++;
      if (o_d1 !== i_d1 || o_d2 !== i_d2 || o_rn !== i_rn || o_write_regfile !== 1'b1 ||
          o_mtc0_we !== c[0] || o_mem_to_regfile !== c[1]) begin
        errors++; $display("FAIL passthrough cyc=%0d got d1=%h d2=%h rn=%0d wr=%b", c, o_d1, o_d2, o_rn, o_write_regfile);
      end
      vectors++;
      if (o_stallreq !== 1'b0 || bus.bus_req !== 1'b0) begin
        errors++; $display("FAIL passthrough_idle cyc=%0d got stallreq=%b req=%b want 0/0", c, o_stallreq, bus.bus_req);
      end
      @(posedge clk); #1;
    end
    bus.bus_ack = 1'b0; i_valid = 1'b0;
  endtask

  task automatic test_stall_hold();
    run_op(5, 32'h300, 32'h0, 32'hCAFEF00D, 2, 3);
    test_passthrough(2);
  endtask

  task automatic test_reset_in_wait();
    i_valid = 1'b1; i_mem_op = 4'd5; i_d1 = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.bus_req !== 1'b0 || o_stallreq !== 1'b0) begin
      errors++; $display("FAIL reset_abort got req=%b stallreq=%b want 0/0", bus.bus_req, o_stallreq);
    end
    @(posedge clk); #1;
    reset = 1'b0; i_valid = 1'b0;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h12345678;
    @(negedge clk);
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.bus_req !== 1'b0 || bus.bus_addr !== 32'h0) begin
      errors++; $display("FAIL stray_ack got req=%b addr=%h want 0/00000000", bus.bus_req, bus.bus_addr);
    end
    @(posedge clk); #1;
    run_op(5, 32'h500, 32'h0, 32'h0BADC0DE, 1, 0);
  endtask

  task automatic test_random(input int n);
    int op, k, hold;
    logic [31:0] addr;
    for (int i = 0; i < n; i++) begin
      op   = $urandom_range(1, 8);
      addr = 32'h1000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (op == 3 || op == 4 || op == 7) addr = addr - (addr % 2);
        if (op == 5 || op == 8) addr = addr - (addr % 4);
      end
      k    = $urandom_range(1, 4);
      hold = $urandom_range(0, 2);
      if (ref_aligned(op, addr)) run_op(op, addr, 32'($urandom), 32'($urandom), k, hold);
      else run_misaligned(op, addr);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_passthrough(3);
    test_stall_hold();
    test_reset_in_wait();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
